// File: rtl/mux41_sel_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux select sequencer.
package mux41_sel_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSettle  = 2'd1,
    StPresent = 2'd2
  } state_e;

  typedef logic [1:0] chan_t;

  localparam int unsigned SettleMin = 1;
  localparam int unsigned SettleMax = 15;
  localparam int unsigned CntWidth  = 4;

  // Channel index to {S1, S0}: S1 carries ch[0], S0 carries ch[1].
  function automatic logic [1:0] chan_to_sel(input chan_t ch);
    return {ch[0], ch[1]};
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping 3->0.
module rr_pick4
  import mux41_sel_pkg::*;
(
  input  logic [3:0] req,
  input  chan_t      last,
  output chan_t      grant,
  output logic       any
);

  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] offset;

  // Rotate so bit 0 is the channel right after 'last', then take the lowest set bit.
  always_comb begin
    req_dbl = {req, req};
    req_rot = 4'(req_dbl >> (3'(last) + 3'd1));
    if (req_rot[0]) begin
      offset = 2'd0;
    end else if (req_rot[1]) begin
      offset = 2'd1;
    end else if (req_rot[2]) begin
      offset = 2'd2;
    end else begin
      offset = 2'd3;
    end
    grant = last + 2'd1 + offset;
    any   = |req;
  end

endmodule

// File: rtl/mux41_rr_sel.sv
// Round-robin select sequencer for a 4:1 mux cell: drives S1/S0, waits SETTLE cycles,
// captures Q_IN and presents it with its channel ID until the consumer acknowledges.
module mux41_rr_sel
  import mux41_sel_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic       Q_IN,
  output logic       S0,
  output logic       S1,
  output logic       VALID,
  output logic       DATA,
  output logic [1:0] ID,
  input  logic       ACK
);

  if (SETTLE < SettleMin || SETTLE > SettleMax) begin : gen_settle_range
    $error("mux41_rr_sel: SETTLE must be within 1..15");
  end

  localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SETTLE - 1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  chan_t               last_q, last_d;
  chan_t               cur_q, cur_d;
  logic                s0_q, s0_d;
  logic                s1_q, s1_d;
  logic                valid_q, valid_d;
  logic                data_q, data_d;
  chan_t               id_q, id_d;

  chan_t               pick_grant;
  logic                pick_any;

  rr_pick4 u_pick (
    .req   (REQ),
    .last  (last_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // Next-state: selects move only on the grant edge; outputs freeze while presenting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cur_d   = cur_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (pick_any) begin
          {s1_d, s0_d} = chan_to_sel(pick_grant);
          cur_d        = pick_grant;
          cnt_d        = SettleLoad;
          state_d      = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          data_d  = Q_IN;
          id_d    = cur_q;
          valid_d = 1'b1;
          last_d  = cur_q;
          state_d = StPresent;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPresent: begin
        if (valid_q && ACK) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; pointer resets to 3 so ch0 wins first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      cur_q   <= 2'd0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign S0    = s0_q;
  assign S1    = s1_q;
  assign VALID = valid_q;
  assign DATA  = data_q;
  assign ID    = id_q;

endmodule

// File: tb/tb_mux41_rr_sel.sv
// Bench for mux41_rr_sel: two instances (SETTLE 2 and 3) share stimulus and are compared
// every cycle against a transaction-level reference model.
module tb_mux41_rr_sel;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       q_in;
  logic       ack;

  logic       s0_2, s1_2, valid_2, data_2;
  logic [1:0] id_2;
  logic       s0_3, s1_3, valid_3, data_3;
  logic [1:0] id_3;

  mux41_rr_sel #(.SETTLE(2)) u_dut2 (
    .CLK   (clk),
    .RST   (rst),
    .REQ   (req),
    .Q_IN  (q_in),
    .S0    (s0_2),
    .S1    (s1_2),
    .VALID (valid_2),
    .DATA  (data_2),
    .ID    (id_2),
    .ACK   (ack)
  );

  mux41_rr_sel #(.SETTLE(3)) u_dut3 (
    .CLK   (clk),
    .RST   (rst),
    .REQ   (req),
    .Q_IN  (q_in),
    .S0    (s0_3),
    .S1    (s1_3),
    .VALID (valid_3),
    .DATA  (data_3),
    .ID    (id_3),
    .ACK   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a transaction is either pending (granted at edge 'start', captured at
  // edge start+settle), being presented (valid), or absent.
  typedef struct packed {
    logic       busy;
    logic       valid;
    logic       data;
    logic [1:0] id;
    logic [1:0] last;
    logic [1:0] cur;
    logic [1:0] sel;
    int         start;
  } mdl_t;

  mdl_t m2, m3;
  int   cyc;
  int   n_vec;
  int   n_err;
  bit   rec_on;
  logic [3:0] rec_q[$];

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.busy  = 1'b0;
    m.valid = 1'b0;
    m.data  = 1'b0;
    m.id    = 2'd0;
    m.last  = 2'd3;
    m.cur   = 2'd0;
    m.sel   = 2'd0;
    m.start = 0;
    return m;
  endfunction

  function automatic int pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input int settle, input int n, input bit r,
                                    input logic [3:0] rq, input logic q, input logic a);
    mdl_t nm;
    int   g;
    nm = m;
    if (r) return mdl_reset();
    if (m.busy) begin
      if (n == m.start + settle) begin
        nm.busy  = 1'b0;
        nm.valid = 1'b1;
        nm.data  = q;
        nm.id    = m.cur;
        nm.last  = m.cur;
      end
    end else if (m.valid) begin
      if (a) nm.valid = 1'b0;
    end else begin
      g = pick(int'(m.last), rq);
      if (g >= 0) begin
        nm.busy  = 1'b1;
        nm.cur   = 2'(g);
        nm.sel   = 2'(g);
        nm.start = n;
      end
    end
    return nm;
  endfunction

  // Expected {0,0,S1,S0,VALID,DATA,ID}: S1 is the low channel bit, S0 the high one.
  function automatic logic [7:0] mdl_out(input mdl_t m);
    logic s1_e, s0_e;
    s1_e = 1'(int'(m.sel) % 2);
    s0_e = 1'(int'(m.sel) / 2);
    return {2'b00, s1_e, s0_e, m.valid, m.data, m.id};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic tick(input bit r, input logic [3:0] rq, input logic q, input logic a);
    rst  = r;
    req  = rq;
    q_in = q;
    ack  = a;
    @(posedge clk);
    cyc++;
    m2 = mdl_step(m2, 2, cyc, r, rq, q, a);
    m3 = mdl_step(m3, 3, cyc, r, rq, q, a);
    @(negedge clk);
    check_eq("dut_settle2", {2'b00, s1_2, s0_2, valid_2, data_2, id_2}, mdl_out(m2));
    check_eq("dut_settle3", {2'b00, s1_3, s0_3, valid_3, data_3, id_3}, mdl_out(m3));
    if (rec_on && valid_2) rec_q.push_back({s1_2, s0_2, id_2});
  endtask

  logic [3:0] exp_seq[5];
  logic       tq;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    cyc    = 0;
    rec_on = 1'b0;
    m2     = mdl_reset();
    m3     = mdl_reset();
    rst    = 1'b1;
    req    = 4'd0;
    q_in   = 1'b0;
    ack    = 1'b0;
    @(negedge clk);

    // Reset, then a single request on ch0 with Q_IN high.
    tick(1, 4'b0000, 1'b0, 1'b0);
    tick(1, 4'b0000, 1'b0, 1'b0);
    check_eq("reset_outputs", {2'b00, s1_2, s0_2, valid_2, data_2, id_2}, 8'h00);
    tick(0, 4'b0001, 1'b1, 1'b0);
    tick(0, 4'b0000, 1'b1, 1'b0);
    tick(0, 4'b0000, 1'b1, 1'b0);
    check_eq("first_capture", {2'b00, s1_2, s0_2, valid_2, data_2, id_2}, 8'b00_0_0_1_1_00);
    tick(0, 4'b0000, 1'b0, 1'b1);

    // All requesters high with ACK held: strict rotation 0,1,2,3,0.
    tick(1, 4'b0000, 1'b0, 1'b0);
    rec_q.delete();
    rec_on = 1'b1;
    for (int i = 0; i < 24; i++) tick(0, 4'b1111, 1'($urandom), 1'b1);
    rec_on = 1'b0;
    exp_seq[0] = {2'b00, 2'd0};
    exp_seq[1] = {2'b10, 2'd1};
    exp_seq[2] = {2'b01, 2'd2};
    exp_seq[3] = {2'b11, 2'd3};
    exp_seq[4] = {2'b00, 2'd0};
    check_eq("rotation_count", 8'(rec_q.size() >= 5), 8'd1);
    for (int i = 0; i < 5 && i < rec_q.size(); i++) begin
      check_eq($sformatf("rotation_%0d", i), 8'(rec_q[i]), 8'(exp_seq[i]));
    end

    // Drain, then ch2 request with ACK withheld: outputs must freeze until the ACK pulse.
    for (int i = 0; i < 6; i++) tick(0, 4'b0000, 1'($urandom), 1'b1);
    for (int i = 0; i < 10; i++) tick(0, 4'b0100, 1'($urandom), 1'b0);
    check_eq("hold_ch2_sel", {6'd0, s1_2, s0_2}, 8'b01);
    tick(0, 4'b0000, 1'b0, 1'b1);
    tick(0, 4'b0000, 1'b0, 1'b0);
    check_eq("ack_clears_valid", {7'd0, valid_2}, 8'd0);

    // Q_IN toggles every cycle so the capture edge is pinned exactly.
    tq = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tq = ~tq;
      tick(0, 4'b0010, tq, 1'b1);
    end

    // Reset mid-settle, then ch3 alone must be granted first.
    for (int i = 0; i < 4; i++) tick(0, 4'b0000, 1'b0, 1'b1);
    tick(0, 4'b0001, 1'b1, 1'b0);
    tick(0, 4'b0000, 1'b1, 1'b0);
    tick(1, 4'b0000, 1'b1, 1'b0);
    check_eq("mid_settle_reset", {2'b00, s1_3, s0_3, valid_3, data_3, id_3}, 8'h00);
    rec_q.delete();
    rec_on = 1'b1;
    for (int i = 0; i < 6; i++) tick(0, 4'b1000, 1'($urandom), 1'b1);
    rec_on = 1'b0;
    check_eq("ch3_grant_seen", 8'(rec_q.size() > 0), 8'd1);
    if (rec_q.size() > 0) check_eq("ch3_first_id", 8'(rec_q[0][1:0]), 8'd3);

    // One-cycle request pulse must still complete.
    for (int i = 0; i < 4; i++) tick(0, 4'b0000, 1'b0, 1'b1);
    tick(0, 4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(0, 4'b0000, 1'b1, 1'b0);
    check_eq("pulse_completes", {7'd0, valid_3}, 8'd1);
    tick(0, 4'b0000, 1'b0, 1'b1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 63) == 0), 4'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux41_rr_sel.md
MUX41_RR_SEL -- requirements
Module: mux41_rr_sel

Interface
REQ-001 Parameter SETTLE, default 2: cycles from select update to Q sampling; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 REQ  input  4  per-channel request; bit k = mux input IN(k+1).
REQ-005 Q_IN  input  1  Q output of the downstream 4:1 mux cell.
REQ-006 S0  output  1  mux select S0, registered.
REQ-007 S1  output  1  mux select S1, registered.
REQ-008 VALID  output  1  captured sample available.
REQ-009 DATA  output  1  captured Q_IN value.
REQ-010 ID  output  2  channel index of DATA.
REQ-011 ACK  input  1  consumer accepts DATA; transfer occurs when VALID and ACK are both high.

Function
REQ-012 Channel-to-select mapping SHALL be fixed as: ch0 (IN1) = S1 0, S0 0; ch1 (IN2) = S1 1, S0 0; ch2 (IN3) = S1 0, S0 1; ch3 (IN4) = S1 1, S0 1; i.e. S1 = ch[0], S0 = ch[1].
REQ-013 The FSM SHALL have states IDLE, SETTLE and PRESENT.
REQ-014 IDLE with REQ == 0: S0, S1, DATA and ID hold their values, VALID = 0.
REQ-015 IDLE with REQ != 0: the block SHALL grant the first requesting channel after the last-granted pointer, searching upward with wrap 3->0.
REQ-016 On that edge the block SHALL load the grant into S1/S0, load the settle counter with SETTLE-1, and go to SETTLE.
REQ-017 SETTLE: the counter decrements each cycle; on the edge where it is 0, DATA <= Q_IN, ID <= granted channel, VALID <= 1, last-granted pointer <= granted channel, go to PRESENT.
REQ-018 Latency: REQ seen in IDLE at edge t -> selects change at edge t -> VALID high after edge t+SETTLE.
REQ-019 PRESENT: VALID, DATA, ID, S0 and S1 SHALL stay stable until ACK; on VALID & ACK, VALID <= 0 and go to IDLE, so there is one bubble cycle before the next grant.
REQ-020 S0 and S1 SHALL change only on the IDLE->SETTLE edge, never during SETTLE or PRESENT.
REQ-021 REQ is sampled only in IDLE; REQ deasserting during SETTLE or PRESENT SHALL NOT abort the transaction.
REQ-022 ACK while VALID = 0 SHALL be ignored.
REQ-023 All four REQ bits continuously high SHALL yield the grant order 0,1,2,3,0,... with no starvation.

Reset
REQ-024 RST high at any edge, including mid-SETTLE or PRESENT, SHALL force: state IDLE, S0 = 0, S1 = 0, VALID = 0, DATA = 0, ID = 0, counter = 0, last-granted pointer = 3 (ch0 highest priority first).
REQ-025 The first arbitration SHALL occur on the first edge with RST low.

Structure
REQ-026 Shared package mux41_sel_pkg SHALL hold the state enum, the 2-bit channel typedef, SETTLE bounds, and the channel-to-{S1,S0} encode function.
REQ-027 The combinational round-robin picker SHALL be the sub-module rr_pick4 (inputs: req[3:0], last[1:0]; outputs: grant[1:0], any).
REQ-028 The target implementation size is 120-400 RTL lines.

Verification
REQ-029 Reset, then REQ = 0001, SETTLE = 2, Q_IN = 1 -> S1/S0 = 00 one edge later; VALID = 1, DATA = 1, ID = 0 two edges after that.
REQ-030 REQ = 1111 held, ACK = 1 -> ID sequence 0,1,2,3,0, with S1/S0 sequence 00,10,01,11,00.
REQ-031 REQ = 0100 with ACK low for 5 cycles -> VALID, DATA and ID frozen; S1 = 0, S0 = 1 unchanged; one ACK pulse -> VALID = 0 next cycle.
REQ-032 Q_IN toggled every cycle during SETTLE with SETTLE = 3 -> DATA equals Q_IN as sampled exactly 3 edges after the select update.
REQ-033 RST asserted mid-SETTLE -> all outputs at reset values next edge; after release with REQ = 1000, first grant is ID = 3.
REQ-034 REQ pulsed for one cycle in IDLE, then dropped -> transaction still completes with VALID = 1.
